// File: rtl/bp_btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_btb_pkg
//  Purpose  : Shared BTB definitions: architectural width and the write-port
//             record that is presented to the branch target buffer.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bp_btb_pkg;

    localparam int RISCV_ARCH = 64;

    // One BTB write request: valid, pc -> npc mapping, and its origin.
    typedef struct packed {
        logic                  v;
        logic [RISCV_ARCH-1:0] pc;
        logic [RISCV_ARCH-1:0] npc;
        logic                  exec;
    } BtbEntryType;

endpackage : bp_btb_pkg
`default_nettype wire

// File: rtl/bp_btb_wrq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_btb_wrq_pkg
//  Purpose  : Types for the BTB write-request queue: the slot record used by
//             both the pre-decode FIFO and the exec holding register.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bp_btb_wrq_pkg;
    import bp_btb_pkg::*;

    localparam int BTB_WRQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic                  v;
        logic [RISCV_ARCH-1:0] pc;
        logic [RISCV_ARCH-1:0] npc;
    } BtbWrqSlotType;

    localparam BtbWrqSlotType BTB_WRQ_SLOT_RESET = '0;

endpackage : bp_btb_wrq_pkg
`default_nettype wire

// File: rtl/bp_btb_wrq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_btb_wrq_if
//  Purpose  : Bundle of the exec / pre-decode request inputs and the BTB
//             write-port outputs of the write-request queue.
//  Ports    : modport slave  - the queue itself
//             modport master - the environment driving requests / BTB ready
//  Revision : 1.0 - initial release
// ============================================================================
interface bp_btb_wrq_if
    import bp_btb_pkg::*;
#(
    parameter int depth = 4
);
    logic                     i_flush_pipeline;
    logic                     i_e;
    logic [RISCV_ARCH-1:0]    i_e_pc;
    logic [RISCV_ARCH-1:0]    i_e_npc;
    logic                     i_pd_valid;
    logic [RISCV_ARCH-1:0]    i_pd_pc;
    logic [RISCV_ARCH-1:0]    i_pd_npc;
    logic                     o_pd_ready;
    logic                     i_btb_ready;
    logic                     o_we;
    logic [RISCV_ARCH-1:0]    o_we_pc;
    logic [RISCV_ARCH-1:0]    o_we_npc;
    logic                     o_we_exec;
    logic [$clog2(depth):0]   o_cnt;

    modport slave (
        input  i_flush_pipeline, i_e, i_e_pc, i_e_npc,
        input  i_pd_valid, i_pd_pc, i_pd_npc, i_btb_ready,
        output o_pd_ready, o_we, o_we_pc, o_we_npc, o_we_exec, o_cnt
    );

    modport master (
        output i_flush_pipeline, i_e, i_e_pc, i_e_npc,
        output i_pd_valid, i_pd_pc, i_pd_npc, i_btb_ready,
        input  o_pd_ready, o_we, o_we_pc, o_we_npc, o_we_exec, o_cnt
    );

endinterface : bp_btb_wrq_if
`default_nettype wire

// File: rtl/bp_btb_wrq.sv
`default_nettype none
// ============================================================================
//  Module   : bp_btb_wrq
//  Purpose  : Write-request queue in front of the BTB write port. Merges
//             high-priority exec updates (never stalled, held in a single
//             newest-wins register) with backpressured pre-decode updates
//             (FIFO of `depth` slots), suppressing duplicate pre-decode pcs
//             and cancelling queued pre-decode slots hit by an exec update.
//  Ports    : i_clk  - clock
//             i_nrst - synchronous active-low reset
//             bus    - bp_btb_wrq_if.slave (requests in, BTB write out)
//  Revision : 1.0 - initial release
// ============================================================================
module bp_btb_wrq
    import bp_btb_pkg::*;
    import bp_btb_wrq_pkg::*;
#(
    parameter int depth = BTB_WRQ_DEPTH_DEFAULT
)(
    input  wire logic         i_clk,
    input  wire logic         i_nrst,
    bp_btb_wrq_if.slave       bus
);
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        BtbEntryType                 out;
        BtbWrqSlotType               ex;
        BtbWrqSlotType [depth-1:0]   slots;
        logic [PTR_W-1:0]            wr;
        logic [PTR_W-1:0]            rd;
        logic [CNT_W-1:0]            cnt;
    } BpBtbWrq_registers;

    localparam BpBtbWrq_registers BpBtbWrq_r_reset = '0;

    BpBtbWrq_registers r_q;
    BpBtbWrq_registers w_d;

    logic          w_loadable;
    logic          w_pd_ready;
    logic          w_pd_hit;
    logic          w_pd_store;
    logic          w_e_taken;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    BtbWrqSlotType w_head;

    always_comb begin
        w_d        = r_q;
        w_e_taken  = 1'b0;
        w_bypass   = 1'b0;
        w_pop      = 1'b0;
        w_head     = r_q.slots[r_q.rd];
        w_loadable = !r_q.out.v || bus.i_btb_ready;
        // Readiness looks only at the registered count, so a pop in the
        // same cycle never frees a slot for the incoming request.
        w_pd_ready = (r_q.cnt < CNT_W'(depth));

        // A pre-decode pc already in flight anywhere is dropped.
        w_pd_hit = (bus.i_e && (bus.i_pd_pc == bus.i_e_pc))
                || (r_q.ex.v && (bus.i_pd_pc == r_q.ex.pc))
                || (r_q.out.v && (bus.i_pd_pc == r_q.out.pc));
        for (int i = 0; i < depth; i++) begin
            if (r_q.slots[i].v && (r_q.slots[i].pc == bus.i_pd_pc)) begin
                w_pd_hit = 1'b1;
            end
        end
        w_pd_store = bus.i_pd_valid && w_pd_ready && !bus.i_flush_pipeline && !w_pd_hit;

        // Output register source selection.
        if (w_loadable) begin
            if (r_q.ex.v) begin
                w_d.out.v    = 1'b1;
                w_d.out.pc   = r_q.ex.pc;
                w_d.out.npc  = r_q.ex.npc;
                w_d.out.exec = 1'b1;
                w_d.ex.v     = 1'b0;
            end else if (bus.i_e) begin
                w_d.out.v    = 1'b1;
                w_d.out.pc   = bus.i_e_pc;
                w_d.out.npc  = bus.i_e_npc;
                w_d.out.exec = 1'b1;
                w_e_taken    = 1'b1;
            end else if (r_q.cnt != '0) begin
                // A cancelled head is discarded without producing a write.
                w_pop = 1'b1;
                w_d.out.v = w_head.v;
                if (w_head.v) begin
                    w_d.out.pc   = w_head.pc;
                    w_d.out.npc  = w_head.npc;
                    w_d.out.exec = 1'b0;
                end
            end else if (w_pd_store) begin
                w_bypass     = 1'b1;
                w_d.out.v    = 1'b1;
                w_d.out.pc   = bus.i_pd_pc;
                w_d.out.npc  = bus.i_pd_npc;
                w_d.out.exec = 1'b0;
            end else begin
                w_d.out.v = 1'b0;
            end
        end

        // Exec requests that miss the output register wait in ex; a newer
        // one replaces an undrained older one.
        if (bus.i_e && !w_e_taken) begin
            w_d.ex.v   = 1'b1;
            w_d.ex.pc  = bus.i_e_pc;
            w_d.ex.npc = bus.i_e_npc;
        end

        w_push = w_pd_store && !w_bypass;

        // Exec cancel: queued pre-decode entries for this pc become holes.
        for (int i = 0; i < depth; i++) begin
            if (bus.i_e && (r_q.slots[i].pc == bus.i_e_pc)) begin
                w_d.slots[i].v = 1'b0;
            end
        end
        // Popped slots are cleared so they stop taking part in dedup.
        if (w_pop) begin
            w_d.slots[r_q.rd].v = 1'b0;
            w_d.rd              = r_q.rd + 1'b1;
        end
        if (w_push) begin
            w_d.slots[r_q.wr].v   = 1'b1;
            w_d.slots[r_q.wr].pc  = bus.i_pd_pc;
            w_d.slots[r_q.wr].npc = bus.i_pd_npc;
            w_d.wr                = r_q.wr + 1'b1;
        end
        w_d.cnt = r_q.cnt + CNT_W'(w_push) - CNT_W'(w_pop);

        if (bus.i_flush_pipeline) begin
            for (int i = 0; i < depth; i++) begin
                w_d.slots[i] = BTB_WRQ_SLOT_RESET;
            end
            w_d.wr  = '0;
            w_d.rd  = '0;
            w_d.cnt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_q <= BpBtbWrq_r_reset;
        end else begin
            r_q <= w_d;
        end
    end

    assign bus.o_pd_ready = w_pd_ready;
    assign bus.o_we       = r_q.out.v;
    assign bus.o_we_pc    = r_q.out.pc;
    assign bus.o_we_npc   = r_q.out.npc;
    assign bus.o_we_exec  = r_q.out.exec;
    assign bus.o_cnt      = r_q.cnt;

endmodule : bp_btb_wrq
`default_nettype wire

// File: tb/tb_bp_btb_wrq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_btb_wrq
//  Purpose  : Directed self-checking bench for the BTB write-request queue.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_btb_wrq;
    import bp_btb_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_err;

    bp_btb_wrq_if #(.depth(DEPTH)) bus ();

    bp_btb_wrq #(.depth(DEPTH)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.i_flush_pipeline = 1'b0;
        bus.i_e              = 1'b0;
        bus.i_e_pc           = '0;
        bus.i_e_npc          = '0;
        bus.i_pd_valid       = 1'b0;
        bus.i_pd_pc          = '0;
        bus.i_pd_npc         = '0;
    endtask

    task automatic pd(input logic [63:0] pc);
        bus.i_pd_valid = 1'b1;
        bus.i_pd_pc    = pc;
        bus.i_pd_npc   = pc + 64'h40;
    endtask

    task automatic ex(input logic [63:0] pc);
        bus.i_e     = 1'b1;
        bus.i_e_pc  = pc;
        bus.i_e_npc = pc + 64'h400;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        idle();
        bus.i_btb_ready = 1'b1;

        // Reset state
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        chk("rst_we", bus.o_we, 1'b0);
        chk("rst_pc", bus.o_we_pc, 64'h0);
        chk("rst_exec", bus.o_we_exec, 1'b0);
        chk("rst_cnt", bus.o_cnt, 0);
        chk("rst_rdy", bus.o_pd_ready, 1'b1);

        // Bypass: one-cycle pre-decode latency
        pd(64'h1000);
        tick();
        idle();
        chk("byp_we", bus.o_we, 1'b1);
        chk("byp_pc", bus.o_we_pc, 64'h1000);
        chk("byp_npc", bus.o_we_npc, 64'h1040);
        chk("byp_exec", bus.o_we_exec, 1'b0);
        chk("byp_cnt", bus.o_cnt, 0);
        tick();
        chk("byp_done", bus.o_we, 1'b0);

        // Priority: exec first, pre-decode queued behind it
        ex(64'h2000);
        pd(64'h3000);
        tick();
        idle();
        chk("pri_we0", bus.o_we, 1'b1);
        chk("pri_pc0", bus.o_we_pc, 64'h2000);
        chk("pri_npc0", bus.o_we_npc, 64'h2400);
        chk("pri_ex0", bus.o_we_exec, 1'b1);
        chk("pri_cnt0", bus.o_cnt, 1);
        tick();
        chk("pri_pc1", bus.o_we_pc, 64'h3000);
        chk("pri_ex1", bus.o_we_exec, 1'b0);
        chk("pri_cnt1", bus.o_cnt, 0);
        tick();
        chk("pri_done", bus.o_we, 1'b0);

        // Full / backpressure: first request bypasses into out, next four fill
        bus.i_btb_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            pd(64'h6000 + 64'(i) * 64'h100);
            tick();
            chk("full_hold_pc", bus.o_we_pc, 64'h6000);
        end
        chk("full_cnt", bus.o_cnt, DEPTH);
        chk("full_rdy", bus.o_pd_ready, 1'b0);
        pd(64'h6500);
        tick();
        idle();
        chk("full_cnt2", bus.o_cnt, DEPTH);
        chk("full_we", bus.o_we, 1'b1);
        bus.i_btb_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("drain_pc", bus.o_we_pc, 64'h6100 + 64'(i) * 64'h100);
            chk("drain_cnt", bus.o_cnt, DEPTH - 1 - i);
        end
        tick();
        chk("drain_done", bus.o_we, 1'b0);

        // Exec cancel of a queued pre-decode slot
        bus.i_btb_ready = 1'b0;
        pd(64'h7000);
        tick();
        pd(64'h4000);
        tick();
        idle();
        chk("cxl_cnt", bus.o_cnt, 1);
        ex(64'h4000);
        tick();
        idle();
        chk("cxl_hold", bus.o_we_pc, 64'h7000);
        bus.i_btb_ready = 1'b1;
        tick();
        chk("cxl_pc", bus.o_we_pc, 64'h4000);
        chk("cxl_exec", bus.o_we_exec, 1'b1);
        chk("cxl_npc", bus.o_we_npc, 64'h4400);
        tick();
        chk("cxl_silent", bus.o_we, 1'b0);
        chk("cxl_cnt0", bus.o_cnt, 0);

        // Dedup against out register
        pd(64'h5000);
        tick();
        chk("dup_pc", bus.o_we_pc, 64'h5000);
        tick();
        idle();
        chk("dup_we", bus.o_we, 1'b0);
        chk("dup_cnt", bus.o_cnt, 0);

        // Dedup against a FIFO slot, then flush with a simultaneous push
        bus.i_btb_ready = 1'b0;
        pd(64'h7100);
        tick();
        pd(64'h5100);
        tick();
        tick();
        chk("dupq_cnt", bus.o_cnt, 1);
        pd(64'h5200);
        tick();
        chk("fl_cnt2", bus.o_cnt, 2);
        bus.i_flush_pipeline = 1'b1;
        pd(64'h5300);
        #1;
        chk("fl_rdy", bus.o_pd_ready, 1'b1);
        tick();
        idle();
        chk("fl_cnt0", bus.o_cnt, 0);
        chk("fl_out", bus.o_we_pc, 64'h7100);
        bus.i_btb_ready = 1'b1;
        tick();
        chk("fl_nowr", bus.o_we, 1'b0);

        // Back-to-back exec throughput
        ex(64'h8000);
        tick();
        chk("thr_pc0", bus.o_we_pc, 64'h8000);
        ex(64'h8100);
        tick();
        idle();
        chk("thr_pc1", bus.o_we_pc, 64'h8100);
        chk("thr_ex1", bus.o_we_exec, 1'b1);
        tick();

        // Exec holding register: newest wins
        bus.i_btb_ready = 1'b0;
        ex(64'h9000);
        tick();
        ex(64'h9100);
        tick();
        ex(64'h9200);
        tick();
        idle();
        chk("ovw_hold", bus.o_we_pc, 64'h9000);
        bus.i_btb_ready = 1'b1;
        tick();
        chk("ovw_pc", bus.o_we_pc, 64'h9200);
        chk("ovw_exec", bus.o_we_exec, 1'b1);
        tick();
        chk("ovw_done", bus.o_we, 1'b0);

        // Reset mid-operation
        bus.i_btb_ready = 1'b0;
        pd(64'hA000);
        tick();
        pd(64'hA100);
        tick();
        pd(64'hA200);
        tick();
        pd(64'hA300);
        tick();
        idle();
        chk("mrst_pre", bus.o_cnt, 3);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("mrst_we", bus.o_we, 1'b0);
        chk("mrst_cnt", bus.o_cnt, 0);
        chk("mrst_rdy", bus.o_pd_ready, 1'b1);
        chk("mrst_pc", bus.o_we_pc, 64'h0);
        bus.i_btb_ready = 1'b1;
        tick();
        chk("mrst_empty", bus.o_we, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bp_btb_wrq
`default_nettype wire
